// File: rtl/led_seq_pkg.sv
// Shared mode/state codes and default geometry for the LED pattern sequencer.
package led_seq_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int CNT_W_DEF = 26;

  typedef enum logic [2:0] {
    MODE_STATIC = 3'd0,
    MODE_WALK   = 3'd1,
    MODE_BOUNCE = 3'd2,
    MODE_COUNT  = 3'd3,
    MODE_BLINK  = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts 0..period-1 while enabled and pulses tick on the wrap cycle.
module led_tick_gen
  import led_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = (cnt_q == (period - ONE));
  assign tick = enable & ~clear & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Configurable LED pattern sequencer with run/pause/step control.
// Optional brightness PWM on the LED drive when LED_PWM_EN is defined.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic             run,
  input  logic             step,
`ifdef LED_PWM_EN
  input  logic [3:0]       bright,
`endif
  output logic             tick_o,
  output logic [1:0]       state_o,
  output logic [WIDTH-1:0] dout
);

  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(TICK_DIV);
  localparam logic [WIDTH-1:0] PAT_LSB    = WIDTH'(1);
  localparam logic [WIDTH-1:0] PAT_MSB    = PAT_LSB << (WIDTH - 1);

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             dir_q, dir_d;   // 0 = left, 1 = right
  logic             ready_q, tick_q;
  logic             accept, pre_tick, adv;

  assign accept = cfg_valid & ready_q;
  // A config accept always takes priority over a pending advance.
  assign adv = ~accept & (pre_tick | ((state_q == ST_PAUSE) & step));

  led_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (state_q == ST_RUN),
    .period (period_q),
    .tick   (pre_tick)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    pat_d    = pat_q;
    seed_d   = seed_q;
    dir_d    = dir_q;

    unique case (state_q)
      ST_IDLE:  if (accept) state_d = run ? ST_RUN : ST_PAUSE;
      ST_RUN:   if (!run)   state_d = ST_PAUSE;
      ST_PAUSE: if (run)    state_d = ST_RUN;
      default:              state_d = ST_IDLE;
    endcase

    if (accept) begin
      mode_d   = cfg_mode;
      period_d = (cfg_period == '0) ? DEF_PERIOD : cfg_period;
      seed_d   = cfg_pattern;
      dir_d    = 1'b0;
      pat_d    = cfg_pattern;
      if ((cfg_mode == MODE_WALK || cfg_mode == MODE_BOUNCE) && cfg_pattern == '0) begin
        pat_d = PAT_LSB;
      end
    end else if (adv) begin
      case (mode_q)
        MODE_WALK:  pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        MODE_BOUNCE: begin
          // End stops reverse direction without repeating the end position.
          if (pat_q == PAT_MSB) begin
            dir_d = 1'b1;
            pat_d = pat_q >> 1;
          end else if (pat_q == PAT_LSB) begin
            dir_d = 1'b0;
            pat_d = pat_q << 1;
          end else begin
            pat_d = dir_q ? (pat_q >> 1) : (pat_q << 1);
          end
        end
        MODE_COUNT: pat_d = pat_q + PAT_LSB;
        MODE_BLINK: pat_d = (pat_q != '0) ? '0 : seed_q;
        default:    pat_d = pat_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_STATIC;
      period_q <= DEF_PERIOD;
      pat_q    <= '0;
      seed_q   <= '0;
      dir_q    <= 1'b0;
      ready_q  <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      pat_q    <= pat_d;
      seed_q   <= seed_d;
      dir_q    <= dir_d;
      ready_q  <= ~accept;
      tick_q   <= adv;
    end
  end

  assign cfg_ready = ready_q;
  assign tick_o    = tick_q;
  assign state_o   = state_q;

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt_q;
  logic       pwm_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= 4'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
    end
  end

  assign pwm_on = (bright == 4'hF) | (pwm_cnt_q < bright);
  assign dout   = (state_q == ST_IDLE) ? '0 : (pat_q & {WIDTH{pwm_on}});
`else
  assign dout   = (state_q == ST_IDLE) ? '0 : pat_q;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_led_seq_ctrl;

  localparam int W  = 10;
  localparam int CW = 26;
  localparam int TD = 50_000_000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [2:0]    cfg_mode = 3'd0;
  logic [CW-1:0] cfg_period = '0;
  logic [W-1:0]  cfg_pattern = '0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          tick_o;
  logic [1:0]    state_o;
  logic [W-1:0]  dout;
`ifdef LED_PWM_EN
  logic [3:0]    bright = 4'hF;
`endif

  int n_chk = 0;
  int n_fail = 0;

  int bexp [12] = '{'h200, 'h100, 'h080, 'h040, 'h020, 'h010,
                    'h008, 'h004, 'h002, 'h001, 'h002, 'h004};

  led_seq_ctrl #(.WIDTH(W), .CNT_W(CW), .TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_period  (cfg_period),
    .cfg_pattern (cfg_pattern),
    .run         (run),
    .step        (step),
`ifdef LED_PWM_EN
    .bright      (bright),
`endif
    .tick_o      (tick_o),
    .state_o     (state_o),
    .dout        (dout)
  );

  always #5 clk = ~clk;

  // Behavioural model: state 0 idle / 1 run / 2 pause, pattern kept as an integer.
  int     m_st, m_mode, m_pat, m_seed, m_dir, m_rdy, m_tick, m_pwm;
  longint m_per, m_cnt;

  task automatic m_reset();
    m_st = 0; m_mode = 0; m_per = TD; m_cnt = 0; m_pat = 0;
    m_seed = 0; m_dir = 0; m_rdy = 1; m_tick = 0; m_pwm = 0;
  endtask

  task automatic m_step();
    int acc;
    int adv;
    acc = (cfg_valid && m_rdy != 0) ? 1 : 0;
    adv = 0;
    if (acc != 0) begin
      m_mode = int'(cfg_mode);
      m_per  = (cfg_period == 0) ? longint'(TD) : longint'(cfg_period);
      m_cnt  = 0;
      m_dir  = 0;
      m_seed = int'(cfg_pattern);
      m_pat  = int'(cfg_pattern);
      if ((m_mode == 1 || m_mode == 2) && m_pat == 0) m_pat = 1;
    end else if (m_st == 1) begin
      if (m_cnt == m_per - 1) begin
        adv = 1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (m_st == 2 && step) begin
      adv = 1;
    end
    if (adv != 0) begin
      case (m_mode)
        1: m_pat = (m_pat * 2) % 1024 + m_pat / 512;
        2: begin
          if (m_pat == 512) begin m_dir = 1; m_pat = 256; end
          else if (m_pat == 1) begin m_dir = 0; m_pat = 2; end
          else m_pat = (m_dir != 0) ? m_pat / 2 : (m_pat * 2) % 1024;
        end
        3: m_pat = (m_pat + 1) % 1024;
        4: m_pat = (m_pat != 0) ? 0 : m_seed;
        default: ;
      endcase
    end
    if (m_st == 0) begin
      if (acc != 0) m_st = run ? 1 : 2;
    end else if (m_st == 1) begin
      if (!run) m_st = 2;
    end else if (run) begin
      m_st = 1;
    end
    m_tick = adv;
    m_rdy  = (acc != 0) ? 0 : 1;
    m_pwm  = (m_pwm + 1) % 16;
  endtask

  function automatic int m_dout();
    if (m_st == 0) return 0;
`ifdef LED_PWM_EN
    if (!(bright == 4'hF || m_pwm < int'(bright))) return 0;
`endif
    return m_pat;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("model_dout",  32'(dout),      32'(m_dout()));
    chk("model_tick",  32'(tick_o),    32'(m_tick));
    chk("model_state", 32'(state_o),   32'(m_st));
    chk("model_ready", 32'(cfg_ready), 32'(m_rdy));
  endtask

  task automatic cyc(input bit v, input int md, input int per, input int pt,
                     input bit r, input bit s);
    cfg_valid   = v;
    cfg_mode    = md[2:0];
    cfg_period  = per[CW-1:0];
    cfg_pattern = pt[W-1:0];
    run         = r;
    step        = s;
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_dout",  32'(dout), 32'h0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_tick",  32'(tick_o), 32'd0);

    // WALK, period 4, zero seed
    cyc(1, 1, 4, 0, 1, 0);
    chk("walk_seed", 32'(dout), 32'h001);
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 1, 4, 0, 1, 0);
      if (i % 4 == 0) begin
        chk("walk_tick", 32'(tick_o), 32'd1);
        chk("walk_pat",  32'(dout), 32'(1 << ((i / 4) % 10)));
      end
    end

    // BOUNCE, period 1, both end stops
    cyc(1, 2, 1, 'h100, 1, 0);
    chk("bounce_seed", 32'(dout), 32'h100);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 2, 1, 0, 1, 0);
      chk("bounce_pat", 32'(dout), 32'(bexp[i]));
    end

    // COUNT wrap
    cyc(1, 3, 1, 'h3FE, 1, 0);
    chk("count_seed", 32'(dout), 32'h3FE);
    cyc(0, 3, 1, 0, 1, 0); chk("count_3ff", 32'(dout), 32'h3FF);
    cyc(0, 3, 1, 0, 1, 0); chk("count_000", 32'(dout), 32'h000);
    cyc(0, 3, 1, 0, 1, 0); chk("count_001", 32'(dout), 32'h001);

    // Pause, prescaler freeze, single step, step ignored in RUN
    cyc(1, 3, 3, 'h010, 1, 0);
    cyc(0, 3, 3, 0, 1, 0);
    cyc(0, 3, 3, 0, 0, 0);
    chk("pause_state", 32'(state_o), 32'd2);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 3, 3, 0, 0, 0);
      chk("pause_hold", 32'(dout), 32'h010);
    end
    cyc(0, 3, 3, 0, 0, 1);
    chk("step_pat",  32'(dout), 32'h011);
    chk("step_tick", 32'(tick_o), 32'd1);
    cyc(0, 3, 3, 0, 0, 0);
    chk("step_once", 32'(dout), 32'h011);
    chk("step_tick_off", 32'(tick_o), 32'd0);
    cyc(0, 3, 3, 0, 1, 0);
    chk("resume_hold", 32'(dout), 32'h011);
    cyc(0, 3, 3, 0, 1, 0);
    chk("resume_adv", 32'(dout), 32'h012);
    cyc(0, 3, 3, 0, 1, 1);
    chk("step_in_run", 32'(dout), 32'h012);
    chk("step_in_run_tick", 32'(tick_o), 32'd0);

    // Accept on the cycle a tick is due
    cyc(1, 1, 2, 'h001, 1, 0);
    cyc(0, 1, 2, 0, 1, 0);
    cyc(1, 0, 5, 'h0F0, 1, 0);
    chk("coll_tick",  32'(tick_o), 32'd0);
    chk("coll_dout",  32'(dout), 32'h0F0);
    chk("coll_ready", 32'(cfg_ready), 32'd0);
    cyc(1, 0, 5, 'h00F, 1, 0);
    chk("holdoff_dout",  32'(dout), 32'h0F0);
    chk("holdoff_ready", 32'(cfg_ready), 32'd1);
    cyc(1, 0, 5, 'h00F, 1, 0);
    chk("second_accept", 32'(dout), 32'h00F);
    cyc(0, 0, 5, 0, 1, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
`ifdef LED_PWM_EN
      bright = 4'($urandom_range(0, 15));
`endif
      cyc(($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 5)), int'($urandom_range(0, 1023)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end
`ifdef LED_PWM_EN
    bright = 4'hF;
`endif

    // Asynchronous reset mid-RUN
    cyc(1, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout",  32'(dout), 32'h0);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    chk("arst_tick",  32'(tick_o), 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 1, 0);
    chk("post_rst_idle", 32'(state_o), 32'd0);
    cyc(1, 3, 1, 5, 0, 0);
    chk("post_rst_pause", 32'(state_o), 32'd2);
    chk("post_rst_dout",  32'(dout), 32'h005);

`ifdef LED_PWM_EN
    begin
      int on_cnt;
      on_cnt = 0;
      bright = 4'd4;
      cyc(1, 0, 1, 'h3FF, 1, 0);
      for (int i = 0; i < 16; i++) begin
        cyc(0, 0, 1, 0, 1, 0);
        if (dout == 10'h3FF) on_cnt++;
      end
      chk("pwm_on_cycles", 32'(on_cnt), 32'd4);
      bright = 4'hF;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
